cnt_4b: RTL and testbench
=========================

Name: cnt_4b

Overview:
- Synchronous 4-bit bounded up/down counter with run/hold control and runtime-programmable lower and upper bounds.
- Used as a general-purpose sequencer/timebase: counts between MIN and MAX inclusive and wraps at either bound.
- Single clock domain. All outputs are registered.

Parameters:
- WIDTH, 4, counter and bound width in bits. All arithmetic is unsigned.

Ports:
- clk   input   1      rising-edge clock
- rst   input   1      reset; asynchronous assert, active-low (0 = reset)
- SS    input   1      start/stop: 1 = count on each clk edge, 0 = hold
- MODE  input   1      direction: 1 = up, 0 = down
- MIN   input   WIDTH  inclusive lower bound, unsigned
- MAX   input   WIDTH  inclusive upper bound, unsigned
- OUT   output  WIDTH  current count, registered

Behaviour:
- Reset
  - rst=0 forces OUT=0 immediately, independent of clk.
  - Release is synchronous in effect: the first update happens at the first rising clk edge with rst=1.
  - Reset asserted mid-count overrides everything. After release, counting restarts from 0, subject to the range rules below.
- Update timing
  - OUT updates only on the rising clk edge, when rst=1 and SS=1.
  - SS=0: OUT holds its value; MODE, MIN and MAX changes have no effect.
- Inputs are sampled at each rising edge and need no internal synchronisation.
- Normal range (MIN <= MAX), up count (MODE=1):
  - OUT < MIN or OUT >= MAX → OUT <= MIN (wrap or re-entry).
  - Otherwise → OUT <= OUT+1.
- Normal range (MIN <= MAX), down count (MODE=0):
  - OUT > MAX or OUT <= MIN → OUT <= MAX (wrap or re-entry).
  - Otherwise → OUT <= OUT-1.
- MIN == MAX: OUT settles to MIN on the first enabled edge and stays there.
- MIN > MAX (invalid range): every enabled edge loads OUT <= MIN. No error flag.
- Arithmetic
  - No modulo-2^WIDTH overflow occurs while in range, because the bound checks precede any increment or decrement.
  - MAX=15 up wraps 15→MIN, and MIN=0 down wraps 0→MAX, with no carry or borrow.
- MODE change while running: the new direction takes effect at the next enabled edge, starting from the current OUT. No extra cycle, no skipped value.
- Bound change while running: the new bounds apply at the next enabled edge. An out-of-range OUT re-enters as described above.
- SS and MODE changing in the same cycle: both new values apply at the same edge.
- Latency: one clock from the enabled edge to the new OUT. No pipelining.

Test Plan:
- Reset and up count: rst=0 → OUT=0 asynchronously. Release rst=1 with SS=1, MODE=1, MIN=0, MAX=15 → OUT steps 1,2,…,15,0,1 on successive edges.
- Direction change: at OUT=5, set MODE=0 → following edges give 4,3,2,1,0,15,14.
- Bounded range and re-entry: MIN=3, MAX=9, up, starting at OUT=0 → 3,4,…,9,3. Switch to down at 6 → 5,4,3,9,8.
- Hold and async reset: SS=0 at OUT=7 for 10 edges → OUT stays 7. Pull rst=0 between edges → OUT=0 before the next edge. After release with SS=1, counting resumes from the MIN-rule value.
- Degenerate bounds:
  - MIN=MAX=4 → OUT=4 after one edge and stays 4 in both modes.
  - MIN=10, MAX=2 → OUT=10 on every enabled edge.
- Bound shrink: counting up at OUT=12 with MIN=0, MAX=15. Change MAX to 8 → next edge OUT=0 (OUT >= MAX), then 1,2,….

Source files
------------

// File: rtl/cnt_4b.sv
// Bounded up/down counter with run/hold control and runtime-programmable
// inclusive bounds. It wraps at either bound and re-enters the range when outside it.
module cnt_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS,
  input  logic             MODE,
  input  logic [WIDTH-1:0] MIN,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] OUT
);

  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] nxt_s;
  logic             below_min_s;
  logic             above_max_s;
  logic             at_or_above_max_s;
  logic             at_or_below_min_s;
  logic             bad_range_s;

  // Range classification of the current count against the live bounds.
  always_comb begin
    below_min_s       = (cnt_r <  MIN);
    above_max_s       = (cnt_r >  MAX);
    at_or_above_max_s = (cnt_r >= MAX);
    at_or_below_min_s = (cnt_r <= MIN);
    bad_range_s       = (MIN >  MAX);
  end

  // Next-count selection. The bound checks come before the +/-1, so the
  // arithmetic never wraps modulo 2^WIDTH.
  always_comb begin
    nxt_s = cnt_r;
    if (!SS) begin
      nxt_s = cnt_r;
    end else if (bad_range_s) begin
      nxt_s = MIN;
    end else if (MODE) begin
      if (below_min_s || at_or_above_max_s) begin
        nxt_s = MIN;
      end else begin
        nxt_s = cnt_r + ONE_C;
      end
    end else begin
      if (above_max_s || at_or_below_min_s) begin
        nxt_s = MAX;
      end else begin
        nxt_s = cnt_r - ONE_C;
      end
    end
  end

  // Count register; an asynchronous reset clears it immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= ZERO_C;
    end else begin
      cnt_r <= nxt_s;
    end
  end

  assign OUT = cnt_r;

endmodule

// File: tb/tb_cnt_4b.sv
// Self-checking bench for cnt_4b: directed vector table, hand-written reset and
// hold sequences, then randomized traffic checked against a range-list model.
module tb_cnt_4b;

  logic       clk;
  logic       rst;
  logic       ss;
  logic       mode;
  logic [3:0] mn;
  logic [3:0] mx;
  logic [3:0] out;

  int vectors;
  int miscompares;

  typedef struct {
    logic       ss;
    logic       mode;
    logic [3:0] mn;
    logic [3:0] mx;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  cnt_4b #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .SS   (ss),
    .MODE (mode),
    .MIN  (mn),
    .MAX  (mx),
    .OUT  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic s, input logic m, input int lo, input int hi, input int e);
    vec_t v;
    v.ss   = s;
    v.mode = m;
    v.mn   = 4'(lo);
    v.mx   = 4'(hi);
    v.exp  = 4'(e);
    tbl.push_back(v);
  endfunction

  // Model: the legal values form the ordered list MIN..MAX; stepping moves one
  // place along that list cyclically, and a count not on the list enters at
  // the end it would reach first.
  function automatic logic [3:0] ref_next(input logic [3:0] cur, input logic s, input logic m,
                                          input logic [3:0] lo, input logic [3:0] hi);
    int vals[$];
    int idx;
    int n;
    if (!s) return cur;
    if (lo > hi) return lo;
    for (int v = int'(lo); v <= int'(hi); v++) vals.push_back(v);
    n = vals.size();
    idx = -1;
    for (int k = 0; k < n; k++) if (vals[k] == int'(cur)) idx = k;
    if (idx < 0) return m ? lo : hi;
    if (m) return 4'(vals[(idx + 1) % n]);
    return 4'(vals[(idx + n - 1) % n]);
  endfunction

  task automatic check(input string nm, input logic [3:0] exp);
    vectors++;
    if (out !== exp) begin
      miscompares++;
      $display("FAIL %s: OUT=%0d expected %0d at %0t", nm, out, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic m, input logic [3:0] lo, input logic [3:0] hi,
                      input logic [3:0] exp, input string nm);
    ss   = s;
    mode = m;
    mn   = lo;
    mx   = hi;
    @(posedge clk);
    #1;
    check(nm, exp);
  endtask

  logic [3:0] mdl;
  logic [3:0] e;
  logic       rs;
  logic       rm;
  logic [3:0] rlo;
  logic [3:0] rhi;
  logic [3:0] tmp;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    ss   = 1'b1;
    mode = 1'b1;
    mn   = 4'd0;
    mx   = 4'd15;

    // Directed table, applied from OUT=0 right after reset release.
    for (int i = 1; i <= 21; i++) add(1'b1, 1'b1, 0, 15, i % 16);
    add(1'b1, 1'b0, 0, 15, 4);  add(1'b1, 1'b0, 0, 15, 3);  add(1'b1, 1'b0, 0, 15, 2);
    add(1'b1, 1'b0, 0, 15, 1);  add(1'b1, 1'b0, 0, 15, 0);  add(1'b1, 1'b0, 0, 15, 15);
    add(1'b1, 1'b0, 0, 15, 14);
    for (int i = 0; i <= 10; i++) add(1'b1, 1'b1, 3, 9, 3 + (i % 7));
    add(1'b1, 1'b0, 3, 9, 5);   add(1'b1, 1'b0, 3, 9, 4);   add(1'b1, 1'b0, 3, 9, 3);
    add(1'b1, 1'b0, 3, 9, 9);   add(1'b1, 1'b0, 3, 9, 8);   add(1'b1, 1'b0, 3, 9, 7);
    for (int i = 0; i < 10; i++) add(1'b0, 1'(i % 2), i, 15 - i, 7);
    add(1'b1, 1'b1, 4, 4, 4);   add(1'b1, 1'b1, 4, 4, 4);
    add(1'b1, 1'b0, 4, 4, 4);   add(1'b1, 1'b0, 4, 4, 4);
    add(1'b1, 1'b1, 10, 2, 10); add(1'b1, 1'b0, 10, 2, 10); add(1'b1, 1'b0, 10, 2, 10);
    add(1'b1, 1'b1, 0, 15, 11); add(1'b1, 1'b1, 0, 15, 12);
    add(1'b1, 1'b1, 0, 8, 0);   add(1'b1, 1'b1, 0, 8, 1);   add(1'b1, 1'b1, 0, 8, 2);

    // Reset asserted between edges clears OUT without a clock edge.
    #2 rst = 1'b0;
    #1 check("reset_async", 4'd0);
    @(posedge clk);
    #1 check("reset_held", 4'd0);
    rst = 1'b1;

    foreach (tbl[i]) step(tbl[i].ss, tbl[i].mode, tbl[i].mn, tbl[i].mx, tbl[i].exp, "table");

    // Hold, then SS and MODE changing together.
    step(1'b0, 1'b1, 4'd0, 4'd15, 4'd2, "hold");
    step(1'b1, 1'b0, 4'd0, 4'd15, 4'd1, "ss_mode_same_edge");
    step(1'b1, 1'b0, 4'd0, 4'd15, 4'd0, "down_to_zero");
    step(1'b1, 1'b0, 4'd0, 4'd15, 4'd15, "down_wrap");

    // Mid-count async reset, then restart under the MIN rule.
    #3 rst = 1'b0;
    #1 check("reset_mid_count", 4'd0);
    @(posedge clk);
    #1 check("reset_over_edge", 4'd0);
    #2 rst = 1'b1;
    step(1'b1, 1'b1, 4'd3, 4'd9, 4'd3, "release_min_rule");
    step(1'b1, 1'b1, 4'd3, 4'd9, 4'd4, "release_count");

    // Randomized traffic against the model.
    mdl = 4'd4;
    rlo = 4'd3;
    rhi = 4'd9;
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(63) == 0) begin
        #3 rst = 1'b0;
        #1 check("rand_reset", 4'd0);
        #1 rst = 1'b1;
        mdl = 4'd0;
      end else begin
        rs = ($urandom_range(3) != 0);
        rm = 1'($urandom_range(1));
        if ($urandom_range(7) == 0) begin
          rlo = 4'($urandom_range(15));
          rhi = 4'($urandom_range(15));
          if ($urandom_range(3) != 0 && rlo > rhi) begin
            tmp = rlo;
            rlo = rhi;
            rhi = tmp;
          end
        end
        e = ref_next(mdl, rs, rm, rlo, rhi);
        step(rs, rm, rlo, rhi, e, "random");
        mdl = e;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
